key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder_pkg.sv | 21 ++
 rtl/key_event_decoder_sync2.sv | 28 ++
 rtl/key_event_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_key_event_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/key_event_decoder_pkg.sv
// key_evt_pkg: shared types and default 125 MHz timing for the key-event decoder.
package key_evt_pkg;

    // Gesture FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        GAP       = 2'd2,
        LONG_HELD = 2'd3
    } key_state_e;

    // Internal counter width.
    localparam int CNT_W = 32;

    // Default timing at 125 MHz.
    localparam int DEBOUNCE_CYC_DEF   = 2_500_000;   // 20 ms
    localparam int LONG_CYC_DEF       = 125_000_000; // 1 s
    localparam int DOUBLE_GAP_CYC_DEF = 37_500_000;  // 0.3 s
    localparam int REPEAT_CYC_DEF     = 25_000_000;  // 0.2 s

endpackage

// File: rtl/key_event_decoder_sync2.sv
// sync2: two-flop synchroniser for one asynchronous input, with a
// configurable reset value so an idle input does not look active at reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns one raw active-low push-button into a debounced
// level and single-cycle short / long / double-click event pulses.
// Optional macro KEY_REPEAT_EN: long_flag auto-repeats every REPEAT_CYC
// cycles while a long press is held (not after a double click).
module key_event_decoder #(
    parameter int DEBOUNCE_CYC   = key_evt_pkg::DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC       = key_evt_pkg::LONG_CYC_DEF,
    parameter int DOUBLE_GAP_CYC = key_evt_pkg::DOUBLE_GAP_CYC_DEF,
`ifdef KEY_REPEAT_EN
    parameter int REPEAT_CYC     = key_evt_pkg::REPEAT_CYC_DEF,
`endif
    parameter int CNT_W          = key_evt_pkg::CNT_W
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic key,
    output logic key_level,
    output logic short_flag,
    output logic long_flag,
    output logic double_flag,
    output logic busy
);

    import key_evt_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYC - 1);
`endif

    // Increment that sticks at the terminal value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] term);
        logic [CNT_W-1:0] res;
        if (cnt >= term) begin
            res = term;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic             key_s;
    logic             pressed_s;
    logic             press_acc_s;
    logic             rel_acc_s;

    logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
    logic             key_level_q, key_level_d;
    key_state_e       state_q,     state_d;
    logic [CNT_W-1:0] tm_cnt_q,    tm_cnt_d;
    logic             second_q,    second_d;
    logic             short_q,     short_d;
    logic             long_q,      long_d;
    logic             double_q,    double_d;
    logic             busy_q,      busy_d;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q,   rep_cnt_d;
    logic             suppress_q,  suppress_d;
`endif

    // Released (1) is the safe reset value of the raw key.
    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (sysclk),
        .rst_n (rst_n),
        .d     (key),
        .q     (key_s)
    );

    assign pressed_s = ~key_s;

    // Debounce: accept a new level once it has differed for DEBOUNCE_CYC cycles.
    always_comb begin
        db_cnt_d    = CNT_ZERO;
        key_level_d = key_level_q;
        press_acc_s = 1'b0;
        rel_acc_s   = 1'b0;
        if (pressed_s != key_level_q) begin
            if (db_cnt_q == DB_TERM) begin
                key_level_d = pressed_s;
                press_acc_s = pressed_s;
                rel_acc_s   = ~pressed_s;
            end else begin
                db_cnt_d = sat_inc(db_cnt_q, DB_TERM);
            end
        end else begin
            db_cnt_d = CNT_ZERO;
        end
    end

    // Gesture FSM: next state, timers and one-cycle event pulses.
    always_comb begin
        state_d    = state_q;
        tm_cnt_d   = tm_cnt_q;
        second_d   = second_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
        double_d   = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        suppress_d = suppress_q;
`endif
        case (state_q)
            IDLE: begin
                tm_cnt_d = CNT_ZERO;
                second_d = 1'b0;
                if (press_acc_s) begin
                    state_d = HELD;
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (rel_acc_s) begin
                    tm_cnt_d = CNT_ZERO;
                    if (second_q) begin
                        double_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = GAP;
                    end
                end else if (tm_cnt_q == LONG_TERM) begin
                    tm_cnt_d = CNT_ZERO;
                    state_d  = LONG_HELD;
                    // A second press held long is still a double click;
                    // it must not also count as a long press.
                    if (second_q) begin
                        double_d = 1'b1;
                    end else begin
                        long_d   = 1'b1;
                    end
`ifdef KEY_REPEAT_EN
                    rep_cnt_d  = CNT_ZERO;
                    suppress_d = second_q;
`endif
                end else begin
                    tm_cnt_d = sat_inc(tm_cnt_q, LONG_TERM);
                end
            end
            GAP: begin
                if (tm_cnt_q == GAP_TERM) begin
                    // Expiry wins over a coincident press; that press
                    // then starts a fresh gesture as if seen from IDLE.
                    short_d  = 1'b1;
                    tm_cnt_d = CNT_ZERO;
                    second_d = 1'b0;
                    if (press_acc_s) begin
                        state_d = HELD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (press_acc_s) begin
                    state_d  = HELD;
                    second_d = 1'b1;
                    tm_cnt_d = CNT_ZERO;
                end else begin
                    tm_cnt_d = sat_inc(tm_cnt_q, GAP_TERM);
                end
            end
            LONG_HELD: begin
                tm_cnt_d = CNT_ZERO;
                if (rel_acc_s) begin
                    state_d = IDLE;
`ifdef KEY_REPEAT_EN
                    suppress_d = 1'b0;
                    rep_cnt_d  = CNT_ZERO;
`endif
                end else begin
                    state_d = LONG_HELD;
`ifdef KEY_REPEAT_EN
                    if (suppress_q) begin
                        rep_cnt_d = CNT_ZERO;
                    end else if (rep_cnt_q == REP_TERM) begin
                        long_d    = 1'b1;
                        rep_cnt_d = CNT_ZERO;
                    end else begin
                        rep_cnt_d = sat_inc(rep_cnt_q, REP_TERM);
                    end
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                tm_cnt_d = CNT_ZERO;
                second_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q    <= CNT_ZERO;
            key_level_q <= 1'b0;
            state_q     <= IDLE;
            tm_cnt_q    <= CNT_ZERO;
            second_q    <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            double_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q   <= CNT_ZERO;
            suppress_q  <= 1'b0;
`endif
        end else begin
            db_cnt_q    <= db_cnt_d;
            key_level_q <= key_level_d;
            state_q     <= state_d;
            tm_cnt_q    <= tm_cnt_d;
            second_q    <= second_d;
            short_q     <= short_d;
            long_q      <= long_d;
            double_q    <= double_d;
            busy_q      <= busy_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            suppress_q  <= suppress_d;
`endif
        end
    end

    assign key_level   = key_level_q;
    assign short_flag  = short_q;
    assign long_flag   = long_q;
    assign double_flag = double_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed, table-driven bench for key_event_decoder
// with short timing (DEBOUNCE 4, LONG 20, GAP 10, REPEAT 8).
// Times are counted in rising edges from the first edge that samples the
// new key pattern; a level change sampled at edge n shows on key_level at
// edge n+5 (two synchroniser edges plus DEBOUNCE_CYC-1 count edges plus
// the register edge).
module tb_key_event_decoder;

    logic sysclk = 1'b0;
    logic rst_n;
    logic key;
    logic key_level;
    logic short_flag;
    logic long_flag;
    logic double_flag;
    logic busy;

    always #4 sysclk = ~sysclk;

    key_event_decoder #(
        .DEBOUNCE_CYC   (4),
        .LONG_CYC       (20),
        .DOUBLE_GAP_CYC (10),
`ifdef KEY_REPEAT_EN
        .REPEAT_CYC     (8),
`endif
        .CNT_W          (32)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .key         (key),
        .key_level   (key_level),
        .short_flag  (short_flag),
        .long_flag   (long_flag),
        .double_flag (double_flag),
        .busy        (busy)
    );

    // One gesture: key low p1, high g, low p2, then released; -1 = never.
    typedef struct {
        string name;
        int    p1;
        int    g;
        int    p2;
        int    rise;
        int    sh_n;
        int    sh_first;
        int    sh_last;
        int    lg_n;
        int    lg_first;
        int    lg_last;
        int    db_n;
        int    db_first;
        int    busy_seen;
    } vec_t;

    vec_t vecs[8];

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor state, written only from the main initial block.
    int rel;
    int m_rise;
    int m_sh_n, m_sh_first, m_sh_last;
    int m_lg_n, m_lg_first, m_lg_last;
    int m_db_n, m_db_first;
    int m_busy_seen;
    int m_multi;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rel         = 0;
        m_rise      = -1;
        m_sh_n      = 0; m_sh_first = -1; m_sh_last = -1;
        m_lg_n      = 0; m_lg_first = -1; m_lg_last = -1;
        m_db_n      = 0; m_db_first = -1;
        m_busy_seen = 0;
        m_multi     = 0;
    endtask

    // Advance one clock and sample outputs on the following falling edge.
    task automatic tick();
        @(posedge sysclk);
        rel = rel + 1;
        @(negedge sysclk);
        if (key_level && m_rise < 0) m_rise = rel;
        if (busy) m_busy_seen = 1;
        if ((int'(short_flag) + int'(long_flag) + int'(double_flag)) > 1) m_multi = m_multi + 1;
        if (short_flag) begin
            if (m_sh_n == 0) m_sh_first = rel;
            m_sh_last = rel;
            m_sh_n    = m_sh_n + 1;
        end
        if (long_flag) begin
            if (m_lg_n == 0) m_lg_first = rel;
            m_lg_last = rel;
            m_lg_n    = m_lg_n + 1;
        end
        if (double_flag) begin
            if (m_db_n == 0) m_db_first = rel;
            m_db_n = m_db_n + 1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int total;
        clear_mon();
        total = v.p1 + v.g + v.p2 + 50;
        for (int i = 0; i < total; i++) begin
            if (i < v.p1)                   key = 1'b0;
            else if (i < v.p1 + v.g)        key = 1'b1;
            else if (i < v.p1 + v.g + v.p2) key = 1'b0;
            else                            key = 1'b1;
            tick();
        end
        check({v.name, " rise"},      m_rise,      v.rise);
        check({v.name, " short_n"},   m_sh_n,      v.sh_n);
        check({v.name, " short_at"},  m_sh_first,  v.sh_first);
        check({v.name, " short_end"}, m_sh_last,   v.sh_last);
        check({v.name, " long_n"},    m_lg_n,      v.lg_n);
        check({v.name, " long_at"},   m_lg_first,  v.lg_first);
        check({v.name, " long_end"},  m_lg_last,   v.lg_last);
        check({v.name, " double_n"},  m_db_n,      v.db_n);
        check({v.name, " double_at"}, m_db_first,  v.db_first);
        check({v.name, " busy_seen"}, m_busy_seen, v.busy_seen);
        check({v.name, " multi"},     m_multi,     0);
        check({v.name, " idle_busy"}, int'(busy),  0);
        check({v.name, " idle_lvl"},  int'(key_level), 0);
    endtask

    initial begin
        //            name         p1  g  p2  rise shN sh1 shL lgN lg1 lgL dbN db1 busy
        vecs[0] = '{"short8",       8,  0,  0,  6,  1, 24, 24,  0, -1, -1,  0, -1, 1};
        vecs[1] = '{"short_min",    4,  0,  0,  6,  1, 20, 20,  0, -1, -1,  0, -1, 1};
        vecs[2] = '{"too_short",    3,  0,  0, -1,  0, -1, -1,  0, -1, -1,  0, -1, 0};
        vecs[3] = '{"double",       8,  5,  8,  6,  0, -1, -1,  0, -1, -1,  1, 27, 1};
`ifdef KEY_REPEAT_EN
        vecs[4] = '{"long_hold",   60,  0,  0,  6,  0, -1, -1,  5, 26, 58,  0, -1, 1};
`else
        vecs[4] = '{"long_hold",   60,  0,  0,  6,  0, -1, -1,  1, 26, 26,  0, -1, 1};
`endif
        vecs[5] = '{"double_hold",  8,  5, 40,  6,  0, -1, -1,  0, -1, -1,  1, 39, 1};
        vecs[6] = '{"gap_last",     8,  9,  8,  6,  0, -1, -1,  0, -1, -1,  1, 31, 1};
        vecs[7] = '{"gap_expire",   8, 10,  8,  6,  2, 24, 42,  0, -1, -1,  0, -1, 1};

        // Reset state.
        rst_n = 1'b0;
        key   = 1'b1;
        clear_mon();
        for (int i = 0; i < 3; i++) tick();
        check("rst key_level", int'(key_level),   0);
        check("rst short",     int'(short_flag),  0);
        check("rst long",      int'(long_flag),   0);
        check("rst double",    int'(double_flag), 0);
        check("rst busy",      int'(busy),        0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Table-driven gestures.
        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v]);
        end

        // Glitch train: five 3-cycle lows with 3-cycle highs.
        clear_mon();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) begin key = 1'b0; tick(); end
            for (int i = 0; i < 3; i++) begin key = 1'b1; tick(); end
        end
        for (int i = 0; i < 20; i++) tick();
        check("glitch rise",   m_rise,      -1);
        check("glitch busy",   m_busy_seen, 0);
        check("glitch short",  m_sh_n,      0);
        check("glitch long",   m_lg_n,      0);
        check("glitch double", m_db_n,      0);

        // Reset in the middle of GAP: key_level falls at 14, GAP runs to 24.
        clear_mon();
        for (int i = 0; i < 8; i++) begin key = 1'b0; tick(); end
        for (int i = 0; i < 10; i++) begin key = 1'b1; tick(); end
        check("gap busy before rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("async rst key_level", int'(key_level),   0);
        check("async rst busy",      int'(busy),        0);
        check("async rst short",     int'(short_flag),  0);
        check("async rst long",      int'(long_flag),   0);
        check("async rst double",    int'(double_flag), 0);
        for (int i = 0; i < 2; i++) tick();
        rst_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 30; i++) tick();
        check("post rst short", m_sh_n,      0);
        check("post rst busy",  m_busy_seen, 0);
        check("post rst rise",  m_rise,      -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
